// File: rtl/gfifo_rd_packer.sv
// gfifo_rd_packer: drains the gray-code FIFO read port (rd_clk domain) and packs
//   NIBBLES entries of DATA_W bits, LSB-first, into one word for a valid/ready sink.
// Latency: word valid the cycle after its last entry is captured; one word per NIBBLES+2 cycles.
// Backpressure: word and count held stable while out_valid & !out_ready; no FIFO reads in HOLD.
// Ports: rd_clk, rst_ (synchronous, active-low); empty/rd_valid/rd_data/rd_req_ (FIFO read
//   side, rd_req_ active-low); out_data/out_cnt/out_valid/out_ready (downstream word);
//   proto_err (sticky: read data arrived with no read outstanding, or while holding a word).
// Option: define GFIFO_PKR_FLUSH_EN to flush a partial word after FLUSH_CYC idle FILL cycles;
//   without it FLUSH_CYC is unused and every output word carries NIBBLES entries.
module gfifo_rd_packer #(
  parameter int DATA_W    = 4,
  parameter int NIBBLES   = 4,
  parameter int FLUSH_CYC = 16
) (
  input  logic                        rd_clk,
  input  logic                        rst_,
  input  logic                        empty,
  input  logic                        rd_valid,
  input  logic [DATA_W-1:0]           rd_data,
  output logic                        rd_req_,
  output logic [DATA_W*NIBBLES-1:0]   out_data,
  output logic [4:0]                  out_cnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        proto_err
);

  localparam int         WORD_W  = DATA_W * NIBBLES;
  localparam logic [4:0] NIB_MAX = 5'(NIBBLES);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state_q,   state_d;
  logic [4:0]        req_cnt_q, req_cnt_d;
  logic [4:0]        cap_cnt_q, cap_cnt_d;
  logic [4:0]        out_cnt_q, out_cnt_d;
  logic [WORD_W-1:0] word_q,    word_d;
  logic              err_q,     err_d;
  logic              issue;
  logic              capture;

`ifdef GFIFO_PKR_FLUSH_EN
  localparam int                IDLE_W    = $clog2(FLUSH_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYC - 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // A read may issue only while filling, with data present and slots left in this word.
  assign issue   = (state_q == ST_FILL) && !empty && (req_cnt_q < NIB_MAX);
  // Read data is only legitimate when a request is still unanswered.
  assign capture = rd_valid && (state_q == ST_FILL) && (req_cnt_q != cap_cnt_q);

  assign rd_req_   = ~issue;
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = word_q;
  assign out_cnt   = out_cnt_q;
  assign proto_err = err_q;

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    cap_cnt_d = cap_cnt_q;
    out_cnt_d = out_cnt_q;
    word_d    = word_q;
    err_d     = err_q;
`ifdef GFIFO_PKR_FLUSH_EN
    idle_d    = '0;
`endif

    if (issue) begin
      req_cnt_d = req_cnt_q + 5'd1;
    end

    // Unsolicited data (or data arriving while a word is held) is dropped and flagged.
    if (rd_valid && !capture) begin
      err_d = 1'b1;
    end

    if (capture) begin
      word_d[int'(cap_cnt_q)*DATA_W +: DATA_W] = rd_data;
      cap_cnt_d = cap_cnt_q + 5'd1;
      if (cap_cnt_d == NIB_MAX) begin
        state_d   = ST_HOLD;
        out_cnt_d = NIB_MAX;
      end
    end

`ifdef GFIFO_PKR_FLUSH_EN
    // Idle means: a partial word exists, nothing is in flight and the FIFO is empty.
    // The word register is already zero above the captured slots, so it ships as-is.
    if ((state_q == ST_FILL) && (cap_cnt_q != 5'd0) && (req_cnt_q == cap_cnt_q) && empty) begin
      if (idle_q == IDLE_LAST) begin
        state_d   = ST_HOLD;
        out_cnt_d = cap_cnt_q;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
`endif

    if ((state_q == ST_HOLD) && out_ready) begin
      state_d   = ST_FILL;
      req_cnt_d = 5'd0;
      cap_cnt_d = 5'd0;
      out_cnt_d = 5'd0;
      word_d    = '0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_) begin
      state_q   <= ST_FILL;
      req_cnt_q <= 5'd0;
      cap_cnt_q <= 5'd0;
      out_cnt_q <= 5'd0;
      word_q    <= '0;
      err_q     <= 1'b0;
`ifdef GFIFO_PKR_FLUSH_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      out_cnt_q <= out_cnt_d;
      word_q    <= word_d;
      err_q     <= err_d;
`ifdef GFIFO_PKR_FLUSH_EN
      idle_q    <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_gfifo_rd_packer.sv
// tb_gfifo_rd_packer: drives gfifo_rd_packer from a queue-based FIFO model and checks every
//   output word against the stream of entries pushed, plus directed literal expectations.
module tb_gfifo_rd_packer;
  localparam int DW = 4;
  localparam int NB = 4;
  localparam int FC = 16;
  localparam int WW = DW * NB;

  logic          rd_clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          empty = 1'b1;
  logic          rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_req_;
  logic [WW-1:0] out_data;
  logic [4:0]    out_cnt;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          proto_err;

  gfifo_rd_packer #(.DATA_W(DW), .NIBBLES(NB), .FLUSH_CYC(FC)) dut (
    .rd_clk(rd_clk), .rst_(rst_), .empty(empty), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_req_(rd_req_), .out_data(out_data), .out_cnt(out_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .proto_err(proto_err)
  );

  always #5 rd_clk = ~rd_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] fifo_q[$];   // entries still inside the modelled FIFO
  logic [DW-1:0] exp_q[$];    // every entry pushed and not yet delivered downstream
  logic          force_empty = 1'b0;
  logic          force_vld = 1'b0;
  logic          req_seen = 1'b0;
  logic          pend = 1'b0;
  logic [DW-1:0] pend_dat = '0;
  logic          exp_err = 1'b0;
  logic          err_pending = 1'b0;
  logic          chk_en = 1'b0;
  int            cyc = 0;
  int            req_low = 0;
  int            hs_cnt = 0;
  int            hs_cyc[$];
  logic [WW-1:0] last_word = '0;
  logic [4:0]    last_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO read port: a request seen low in one cycle returns data in the next.
  initial begin : fifo_model
    forever begin
      @(posedge rd_clk);
      #1;
      cyc++;
      if (err_pending) exp_err = 1'b1;
      if (req_seen && fifo_q.size() > 0) begin
        pend     = 1'b1;
        pend_dat = fifo_q.pop_front();
      end else begin
        pend = 1'b0;
      end
      err_pending = force_vld && !pend;
      rd_valid = pend | force_vld;
      rd_data  = pend ? pend_dat : 4'h9;
      empty    = (fifo_q.size() == 0) || force_empty;
      @(negedge rd_clk);
      req_seen = !rd_req_ && rst_;
      if (req_seen) req_low++;
    end
  end

  // Per-cycle comparison against the entry stream.
  always @(negedge rd_clk) begin
    if (chk_en && rst_) begin
      logic [WW-1:0] w;
      int avail;
      int k;
      check("proto_err", {31'd0, proto_err}, {31'd0, exp_err});
      if (!rd_req_) check("req_while_empty", {31'd0, empty}, 32'd0);
      if (out_valid) begin
        check("req_in_hold", {31'd0, rd_req_}, 32'd1);
        avail = exp_q.size() - fifo_q.size();
`ifdef GFIFO_PKR_FLUSH_EN
        k = (avail < NB) ? avail : NB;
`else
        k = NB;
`endif
        check("entries_avail", {31'd0, avail >= k}, 32'd1);
        w = '0;
        for (int i = 0; i < k && i < exp_q.size(); i++) w[i*DW +: DW] = exp_q[i];
        check("out_data", {16'd0, out_data}, {16'd0, w});
        check("out_cnt", {27'd0, out_cnt}, 32'(k));
        if (out_ready) begin
          for (int i = 0; i < k; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs_cnt++;
          hs_cyc.push_back(cyc);
          last_word = out_data;
          last_cnt  = out_cnt;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge rd_clk);
      #2;
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < max) begin
      step();
      k++;
    end
    check(name, {31'd0, k < max}, 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rd_req_"}, {31'd0, rd_req_}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    check({tag, "_out_cnt"}, {27'd0, out_cnt}, 32'd0);
    check({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    exp_err = 1'b0;
    err_pending = 1'b0;
    step();
    exp_err = 1'b0;
    reset_checks("rst");
    rst_ = 1'b1;
  endtask

  initial begin : main
    int r0;
    int h0;
    int pushes;
    step(3);
    reset_checks("init");
    rst_ = 1'b1;
    chk_en = 1'b1;
    step();

    // 1: single word, exactly NB requests
    r0 = req_low;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    wait_drain("t1_drain", 40);
    check("t1_word", {16'd0, last_word}, 32'h4321);
    check("t1_cnt", {27'd0, last_cnt}, 32'd4);
    check("t1_req_cycles", 32'(req_low - r0), 32'd4);

    // 2: backpressure holds the first word, no reads meanwhile
    out_ready = 1'b0;
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    push(4'hE); push(4'hF); push(4'h1); push(4'h2);
    begin
      int k = 0;
      while (!out_valid && k < 40) begin step(); k++; end
      check("t2_valid_seen", {31'd0, out_valid}, 32'd1);
    end
    r0 = req_low;
    for (int i = 0; i < 20; i++) begin
      check("t2_held_word", {16'd0, out_data}, 32'hDCBA);
      check("t2_held_rdreq", {31'd0, rd_req_}, 32'd1);
      step();
    end
    check("t2_no_reads", 32'(req_low - r0), 32'd0);
    out_ready = 1'b1;
    wait_drain("t2_drain", 60);
    check("t2_word2", {16'd0, last_word}, 32'h21FE);

    // 3: empty pulsing between entries
    for (int i = 1; i <= 4; i++) push(DW'(i));
    for (int i = 0; i < 30; i++) begin
      force_empty = ~force_empty;
      step();
    end
    force_empty = 1'b0;
    wait_drain("t3_drain", 40);
    check("t3_word", {16'd0, last_word}, 32'h4321);
    check("t3_proto_err", {31'd0, proto_err}, 32'd0);

    // throughput: back-to-back words every NB+2 cycles
    hs_cyc.delete();
    for (int i = 0; i < 12; i++) push(DW'(i + 3));
    wait_drain("tp_drain", 80);
    check("tp_words", 32'(hs_cyc.size()), 32'd3);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("tp_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(NB + 2));

    // 4: unsolicited rd_valid
    force_vld = 1'b1;
    step();
    force_vld = 1'b0;
    step();
    check("t4_proto_err", {31'd0, proto_err}, 32'd1);
    push(4'h8); push(4'h7); push(4'h6); push(4'h5);
    wait_drain("t4_drain", 40);
    check("t4_word", {16'd0, last_word}, 32'h5678);
    check("t4_err_sticky", {31'd0, proto_err}, 32'd1);

    // 5: reset after two captures discards the partial word
    push(4'hF); push(4'hE);
    step(8);
    do_reset();
    step();
    push(4'h2); push(4'h4); push(4'h6); push(4'h8);
    wait_drain("t5_drain", 40);
    check("t5_word", {16'd0, last_word}, 32'h8642);

    // 6: partial word then idle
    h0 = hs_cnt;
    push(4'h5); push(4'h6); push(4'h7);
`ifdef GFIFO_PKR_FLUSH_EN
    wait_drain("t6_drain", 80);
    check("t6_word", {16'd0, last_word}, 32'h0765);
    check("t6_cnt", {27'd0, last_cnt}, 32'd3);
`else
    step(40);
    check("t6_no_word", 32'(hs_cnt - h0), 32'd0);
    check("t6_valid_low", {31'd0, out_valid}, 32'd0);
    do_reset();
`endif
    step();

    // random traffic
    pushes = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        push(DW'($urandom_range(0, 15)));
        pushes++;
      end
      force_empty = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    while (pushes % NB != 0) begin
      push(DW'($urandom_range(0, 15)));
      pushes++;
    end
    force_empty = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain", 400);
    check("rand_proto_err", {31'd0, proto_err}, 32'd0);

    chk_en = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
